// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC sequencer: operand number format, the Scalar beat and FSM encodings.
`ifndef NUMBER
`define NUMBER logic [31:0]
`endif

package mac_seq_ctrl_pkg;

  typedef `NUMBER number_t;

  typedef struct packed {
    number_t value;
    logic    valid;
  } scalar_t;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle between the tile scheduler, operand buffers, MAC and result consumer.
// master = sequencer side, slave = environment side.
interface mac_seq_ctrl_if #(
  parameter int unsigned K_W = 10
) ();
  import mac_seq_ctrl_pkg::*;

  logic           start;
  logic [K_W-1:0] k_len;
  logic           busy;
  logic           rd_en;
  logic [K_W-1:0] rd_addr;
  number_t        rd_data_a;
  number_t        rd_data_b;
  logic           mac_clear;
  scalar_t        mac_data;
  scalar_t        mac_weight;
  number_t        mac_out;
  logic           res_valid;
  logic           res_ready;
  number_t        res_data;

  modport master (
    input  start, k_len, rd_data_a, rd_data_b, mac_out, res_ready,
    output busy, rd_en, rd_addr, mac_clear, mac_data, mac_weight, res_valid, res_data
  );

  modport slave (
    output start, k_len, rd_data_a, rd_data_b, mac_out, res_ready,
    input  busy, rd_en, rd_addr, mac_clear, mac_data, mac_weight, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: clears the MAC, streams K operand pairs, then holds the result.
// Optional MAC_SEQ_PERF_EN adds perf_cycles / perf_jobs counters.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned K_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_seq_ctrl_if.master      bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_jobs
`endif
);

  logic [2:0]     state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [K_W-1:0] addr_q, addr_d;
  logic           beat_vld_q, beat_vld_d;
  logic           rd_en;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          k_d     = bus.k_len;
          addr_d  = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        if (k_q == '0) begin
          state_d = StHold;
        end else if (k_q == K_W'(1)) begin
          state_d = StDrain;
        end else begin
          addr_d  = K_W'(1);
          state_d = StStream;
        end
      end
      StStream: begin
        // Last index issued this cycle; park the address so it never wraps.
        if (addr_q == k_q - K_W'(1)) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + K_W'(1);
        end
      end
      StDrain: state_d = StHold;
      StHold: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_en      = ((state_q == StClear) && (k_q != '0)) || (state_q == StStream);
  assign beat_vld_d = rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      addr_q     <= '0;
      beat_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      beat_vld_q <= beat_vld_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = addr_q;
  assign bus.mac_clear  = (state_q == StClear);
  assign bus.mac_data   = '{value: bus.rd_data_a, valid: beat_vld_q};
  assign bus.mac_weight = '{value: bus.rd_data_b, valid: beat_vld_q};
  assign bus.res_valid  = (state_q == StHold);
  assign bus.res_data   = bus.mac_out;

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_jobs_q, perf_jobs_d;

  always_comb begin
    cyc_d         = cyc_q;
    perf_cycles_d = perf_cycles_q;
    perf_jobs_d   = perf_jobs_q;
    if (state_q == StIdle) begin
      cyc_d = '0;
    end else if (state_q != StHold) begin
      cyc_d = cyc_q + 32'd1;
    end
    // Count includes the cycle in which HOLD is being entered.
    if ((state_d == StHold) && (state_q != StHold)) perf_cycles_d = cyc_q + 32'd1;
    if ((state_q == StHold) && bus.res_ready) perf_jobs_d = perf_jobs_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= '0;
      perf_cycles_q <= '0;
      perf_jobs_q   <= '0;
    end else begin
      cyc_q         <= cyc_d;
      perf_cycles_q <= perf_cycles_d;
      perf_jobs_q   <= perf_jobs_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for a single MAC accumulator: runs one K-length dot product per job.
- Reads operand pairs from two 1-cycle-latency operand buffers and streams them to the MAC as Scalar beats.
- Clears the accumulator before each job and returns the result over a valid/ready handshake.
- Sits between the MM tile scheduler (start/k_len) and the MAC plus its operand buffers.

Parameters:
K_W, 10, width of k_len and rd_addr; max job length 2^K_W-1

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
k_len  in  K_W  element count, sampled with start
busy  out  1  high in every state except IDLE
rd_en  out  1  operand buffer read strobe
rd_addr  out  K_W  operand index, shared by both buffers
rd_data_a  in  `NUMBER  data operand, valid 1 cycle after rd_en
rd_data_b  in  `NUMBER  weight operand, valid 1 cycle after rd_en
mac_clear  out  1  drives MAC clear
mac_data  out  Scalar  drives MAC data (value, valid)
mac_weight  out  Scalar  drives MAC weight (value, valid)
mac_out  in  `NUMBER  MAC accumulator output
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  `NUMBER  dot-product result

Behaviour:
- Reset values: state IDLE; busy, rd_en, mac_clear, res_valid = 0; rd_addr = 0; beat-valid register = 0.
- mac_data.value/mac_weight.value come straight from rd_data_a/rd_data_b.
- mac_data.valid and mac_weight.valid both equal a 1-cycle-delayed copy of rd_en.
- States and transitions:
  - IDLE: start=1 latches k_len into K, goes to CLEAR.
  - CLEAR (1 cycle): mac_clear=1. If K>0: rd_en=1, rd_addr=0. Next state:
    - K=0: HOLD
    - K=1: DRAIN
    - K>1: STREAM
  - STREAM: rd_en=1; rd_addr increments by 1 per cycle from 1 to K-1. When rd_addr=K-1 is issued, go to DRAIN.
  - DRAIN (1 cycle): last beat is valid at the MAC; the accumulator captures it at the end of this cycle. Go to HOLD.
  - HOLD: res_valid=1, res_data=mac_out (stable throughout HOLD). When res_ready=1, go to IDLE.
- Latency:
  - start sampled at edge t0; beats valid at cycles t2..t(K+1).
  - res_valid first high in cycle t(K+2).
  - K=0 gives res_valid at t2 with res_data=0.
- Throughput: one beat per cycle, no bubbles. The next job may start the cycle after the HOLD handshake completes.
- Boundary cases:
  - start while busy: ignored, no queueing.
  - k_len changing mid-job: no effect.
  - rd_addr never exceeds K-1 and does not wrap.
  - res_ready with res_valid=0: ignored.
- Reset mid-job: immediate return to IDLE, all outputs to reset values. The MAC is reset by the same rst_n; no partial result is emitted.
- Floating-point arithmetic lives entirely in the MAC; this block never modifies values.

Optional Feature:
MAC_SEQ_PERF_EN
- Defined:
  - Adds output perf_cycles (32 bits): the cycle count from CLEAR entry to first res_valid.
  - perf_cycles is loaded when HOLD is entered and held until the next HOLD entry; reset value 0.
  - Adds output perf_jobs (32 bits): completed-handshake count, wraps at 2^32.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- State enum (IDLE, CLEAR, STREAM, DRAIN, HOLD) goes into the shared Types.sv package, next to Scalar and `NUMBER.
- No sub-module: FSM, address counter and beat-valid register are one small unit.
- Integration wrapper mac_seq_top instantiates mac_seq_ctrl plus MAC.

Test Plan:
- Values are IEEE-754 single precision.
- K=3, A=[1.0,2.0,3.0] (0x3F800000, 0x40000000, 0x40400000), B=[2.0,2.0,2.0] -> res_data=0x41400000 (12.0), res_valid first at t5.
- K=0, start -> mac_clear pulses once, no rd_en, res_valid at t2, res_data=0.
- Back-to-back jobs: K=2 (result 0x40A00000) then K=1 with A=B=1.0 -> second result 0x3F800000, proving clear between jobs.
- HOLD with res_ready low for 10 cycles -> res_valid and res_data stable; start pulses during this window ignored; IDLE one cycle after res_ready=1.
- rst_n low in STREAM at rd_addr=5 of K=8 -> all outputs reset asynchronously; new K=1 job completes correctly.
- K=1023 (maximum) -> rd_addr 0..1022 consecutive with no wrap; res_valid at t1025.
